// File: rtl/microsequencer_if.sv
// Control-word, status and address bundle between the microstore
// front end and the microsequencer.
interface microsequencer_if;
    logic [2:0] n_sel;
    logic       inv;
    logic [1:0] cond_sel;
    logic [9:0] cr_addr;
    logic [3:0] cond_in;
    logic [9:0] enc_state;
    logic       stall;
    logic [9:0] next_state;
    logic       illegal;
    logic       stack_err;

    modport master (
        output n_sel, inv, cond_sel, cr_addr, cond_in, enc_state, stall,
        input  next_state, illegal, stack_err
    );

    modport slave (
        input  n_sel, inv, cond_sel, cr_addr, cond_in, enc_state, stall,
        output next_state, illegal, stack_err
    );
endinterface

// File: rtl/microsequencer.sv
// Next-address microsequencer: branch/condition select, LIFO call
// stack with overflow/underflow tracking and illegal-address trap.
module microsequencer #(
    parameter int NUM_STATES  = 50,
    parameter int STACK_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    microsequencer_if.slave bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

    logic [9:0]    state_q, state_d;
    logic [9:0]    stack_q [STACK_DEPTH];
    logic [9:0]    stack_d [STACK_DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          stack_err_q, stack_err_d;
    logic          cond;
    logic [9:0]    inc;
    logic [9:0]    target;
    logic [CW-1:0] top;

    always_comb begin
        cond        = bus.cond_in[bus.cond_sel] ^ bus.inv;
        inc         = state_q + 10'd1;
        top         = cnt_q - CW'(1);
        target      = '0;
        state_d     = state_q;
        stack_d     = stack_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        stack_err_d = stack_err_q;
        if (!bus.stall) begin
            unique case (bus.n_sel)
                3'b000: target = bus.enc_state;
                3'b001: target = '0;
                3'b010: target = bus.cr_addr;
                3'b011: target = inc;
                3'b100: target = cond ? bus.cr_addr : inc;
                3'b101: target = cond ? bus.cr_addr : bus.enc_state;
                3'b110: begin
                    target = bus.cr_addr;
                    // Full stack: slide everything down, losing the oldest.
                    if (cnt_q == FULL) begin
                        for (int i = 0; i < STACK_DEPTH - 1; i++)
                            stack_d[i] = stack_q[i+1];
                        stack_d[STACK_DEPTH-1] = inc;
                        stack_err_d = 1'b1;
                    end else begin
                        stack_d[cnt_q[PW-1:0]] = inc;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                3'b111: begin
                    if (cnt_q == '0) begin
                        target      = '0;
                        stack_err_d = 1'b1;
                    end else begin
                        target = stack_q[top[PW-1:0]];
                        cnt_d  = top;
                    end
                end
            endcase
            if ({1'b0, target} >= 11'(NUM_STATES)) begin
                target    = '0;
                illegal_d = 1'b1;
            end
            state_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= '0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            stack_err_q <= stack_err_d;
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.next_state = state_q;
    assign bus.illegal    = illegal_q;
    assign bus.stack_err  = stack_err_q;
endmodule
